// File: rtl/matrix_key_scan_if.sv
// ---------------------------------------------------------------------------
// matrix_key_scan_if
//   Bundles the key-matrix pins and the key-event outputs of matrix_key_scan.
//   Optional macro: KEY_RELEASE_FLAG_EN (adds the KEY_REL release pulse).
// Signals
//   ROW_IN     4  matrix rows from the board, pulled up, low = key closed
//   COL_OUT    4  column drive, low = driven column
//   KEY_VALID  1  one-cycle pulse per debounced press
//   KEY_CODE   4  {row[1:0],col[1:0]} of the last accepted key
//   KEY_DOWN   1  high while a debounced key is held
//   KEY_REL    1  one-cycle pulse on debounced release (KEY_RELEASE_FLAG_EN only)
// Modports
//   master  the scan controller (drives columns and key events)
//   slave   board/application side (drives rows, consumes key events)
// ---------------------------------------------------------------------------
interface matrix_key_scan_if;
  logic [3:0] ROW_IN;
  logic [3:0] COL_OUT;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       KEY_DOWN;
`ifdef KEY_RELEASE_FLAG_EN
  logic       KEY_REL;

  modport master (
    input  ROW_IN,
    output COL_OUT, KEY_VALID, KEY_CODE, KEY_DOWN, KEY_REL
  );

  modport slave (
    output ROW_IN,
    input  COL_OUT, KEY_VALID, KEY_CODE, KEY_DOWN, KEY_REL
  );
`else
  modport master (
    input  ROW_IN,
    output COL_OUT, KEY_VALID, KEY_CODE, KEY_DOWN
  );

  modport slave (
    output ROW_IN,
    input  COL_OUT, KEY_VALID, KEY_CODE, KEY_DOWN
  );
`endif
endinterface

// File: rtl/matrix_key_scan.sv
// ---------------------------------------------------------------------------
// matrix_key_scan
//   Scan controller for a 4x4 active-low key matrix. Drives one column low at
//   a time, samples the synchronised rows, debounces the located key and
//   reports one key code per debounced press. Single-key reporting only.
//   Optional macro: KEY_RELEASE_FLAG_EN -> KEY_REL pulses on debounced release.
// Parameters
//   SETTLE_CYC  cycles each column is driven before rows are sampled (>=2)
//   DEB_CYC     stable cycles needed to accept a press or a release
// Ports
//   CLK   system clock
//   nRST  asynchronous active-low reset
//   kif   matrix_key_scan_if.master: ROW_IN in, COL_OUT/KEY_* out
// ---------------------------------------------------------------------------
module matrix_key_scan #(
  parameter int SETTLE_CYC = 4,
  parameter int DEB_CYC    = 1_000_000
) (
  input  logic              CLK,
  input  logic              nRST,
  matrix_key_scan_if.master kif
);

  // Timer also paces the column settle time, so it must hold either count.
  localparam int TW_D = $clog2(DEB_CYC + 1);
  localparam int TW_S = $clog2(SETTLE_CYC + 1);
  localparam int TW   = (TW_D > TW_S) ? TW_D : TW_S;

  localparam logic [TW-1:0] TIMER_ZERO     = {TW{1'b0}};
  localparam logic [TW-1:0] TIMER_ONE      = TW'(1);
  localparam logic [TW-1:0] TIMER_DEB_LAST = TW'(DEB_CYC - 1);
  localparam logic [TW-1:0] TIMER_SET_LAST = TW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN      = 3'd1,
    ST_DEB_PRESS = 3'd2,
    ST_HOLD      = 3'd3,
    ST_DEB_REL   = 3'd4
  } state_t;

  // Lowest-index low row; only meaningful when at least one row is low.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  logic [3:0]    row_meta_q;
  logic [3:0]    row_sync_q;
  state_t        state_q,     state_d;
  logic [TW-1:0] timer_q,     timer_d;
  logic [1:0]    col_q,       col_d;
  logic [1:0]    row_lat_q,   row_lat_d;
  logic [3:0]    col_out_q,   col_out_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q,  key_code_d;
  logic          key_down_q,  key_down_d;
  logic          key_rel_q,   key_rel_d;
  logic          lat_row_high;

  assign lat_row_high = row_sync_q[row_lat_q];

  // Two-flop synchroniser for the asynchronous row pins (idle = all high).
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
    end else begin
      row_meta_q <= kif.ROW_IN;
      row_sync_q <= row_meta_q;
    end
  end

  // Next-state and output logic of the scan/debounce FSM.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    col_d       = col_q;
    row_lat_d   = row_lat_q;
    col_out_d   = col_out_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_down_d  = key_down_q;
    key_rel_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // All columns driven: any closed key pulls a row low.
        col_out_d = 4'b0000;
        timer_d   = TIMER_ZERO;
        if (row_sync_q != 4'b1111) begin
          state_d   = ST_SCAN;
          col_d     = 2'd0;
          col_out_d = 4'b1110;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_SCAN: begin
        if (timer_q == TIMER_SET_LAST) begin
          timer_d = TIMER_ZERO;
          if (row_sync_q != 4'b1111) begin
            // Keep the column driven so the latched row keeps tracking the key.
            row_lat_d = low_row(row_sync_q);
            state_d   = ST_DEB_PRESS;
          end else if (col_q == 2'd3) begin
            state_d   = ST_IDLE;
            col_d     = 2'd0;
            col_out_d = 4'b0000;
          end else begin
            col_d     = col_q + 2'd1;
            col_out_d = {col_out_q[2:0], col_out_q[3]};
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      ST_DEB_PRESS: begin
        if (lat_row_high) begin
          state_d   = ST_IDLE;
          timer_d   = TIMER_ZERO;
          col_out_d = 4'b0000;
        end else if (timer_q == TIMER_DEB_LAST) begin
          state_d     = ST_HOLD;
          timer_d     = TIMER_ZERO;
          key_valid_d = 1'b1;
          key_code_d  = {row_lat_q, col_q};
          key_down_d  = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      ST_HOLD: begin
        timer_d = TIMER_ZERO;
        if (lat_row_high) begin
          state_d = ST_DEB_REL;
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_DEB_REL: begin
        if (!lat_row_high) begin
          state_d = ST_HOLD;
          timer_d = TIMER_ZERO;
        end else if (timer_q == TIMER_DEB_LAST) begin
          state_d    = ST_IDLE;
          timer_d    = TIMER_ZERO;
          col_d      = 2'd0;
          col_out_d  = 4'b0000;
          key_down_d = 1'b0;
          key_rel_d  = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      default: begin
        // Unreachable encoding: fall back to the reset picture.
        state_d     = ST_IDLE;
        timer_d     = TIMER_ZERO;
        col_d       = 2'd0;
        row_lat_d   = 2'd0;
        col_out_d   = 4'b0000;
        key_valid_d = 1'b0;
        key_code_d  = 4'h0;
        key_down_d  = 1'b0;
        key_rel_d   = 1'b0;
      end
    endcase
  end

  // FSM state, timer and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      timer_q     <= TIMER_ZERO;
      col_q       <= 2'd0;
      row_lat_q   <= 2'd0;
      col_out_q   <= 4'b0000;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_down_q  <= 1'b0;
      key_rel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      col_q       <= col_d;
      row_lat_q   <= row_lat_d;
      col_out_q   <= col_out_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_down_q  <= key_down_d;
      key_rel_q   <= key_rel_d;
    end
  end

  assign kif.COL_OUT   = col_out_q;
  assign kif.KEY_VALID = key_valid_q;
  assign kif.KEY_CODE  = key_code_q;
  assign kif.KEY_DOWN  = key_down_q;
`ifdef KEY_RELEASE_FLAG_EN
  assign kif.KEY_REL   = key_rel_q;
`else
  // Release pulse is not exported in this build.
  logic unused_key_rel;
  assign unused_key_rel = key_rel_q;
`endif

endmodule

// File: tb/tb_matrix_key_scan.sv
module tb_matrix_key_scan;
  localparam int S = 4;
  localparam int D = 16;

  logic        clk  = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] keys = 16'h0000;   // bit r*4+c = key at row r, column c closed
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  logic [3:0]  exp_code_q[$];
  int          exp_lat_q[$];
  int          exp_cyc_q[$];
  int          rel_pending = 0;
  logic        prev_valid  = 1'b0;

  logic        trace_en = 1'b0;
  logic [3:0]  last_col = 4'b0000;
  logic [3:0]  col_trace[$];

  matrix_key_scan_if kif();

  matrix_key_scan #(.SETTLE_CYC(S), .DEB_CYC(D)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .kif  (kif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Board model: a row is pulled low when a closed key sits on a driven column.
  function automatic logic [3:0] board_rows(input logic [15:0] k, input logic [3:0] cols);
    logic [3:0] r_out;
    r_out = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (k[r*4+c] && !cols[c]) r_out[r] = 1'b0;
    return r_out;
  endfunction

  assign kif.ROW_IN = board_rows(keys, kif.COL_OUT);

  // Reference: scanning visits column 0 first, lowest row in that column wins.
  function automatic int ref_code(input logic [15:0] k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[r*4+c]) return r*4 + c;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every KEY_VALID pulse is matched against the scoreboard.
  always @(negedge clk) begin
    logic [3:0] code_e;
    int lat_e, pc_e, dl;
    if (kif.KEY_VALID) begin
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_width actual=2+ cycles expected=1 cycle");
      end
      if (exp_code_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid actual=code %0h expected=no pulse", kif.KEY_CODE);
      end else begin
        code_e = exp_code_q.pop_front();
        lat_e  = exp_lat_q.pop_front();
        pc_e   = exp_cyc_q.pop_front();
        checks++;
        if (kif.KEY_CODE !== code_e) begin
          errors++;
          $display("FAIL key_code actual=%0h expected=%0h", kif.KEY_CODE, code_e);
        end
        checks++;
        if (kif.KEY_DOWN !== 1'b1) begin
          errors++;
          $display("FAIL down_with_valid actual=%b expected=1", kif.KEY_DOWN);
        end
        if (lat_e >= 0) begin
          dl = cyc - pc_e;
          checks++;
          if (dl < lat_e - 1 || dl > lat_e + 1) begin
            errors++;
            $display("FAIL press_latency actual=%0d expected=%0d+/-1", dl, lat_e);
          end
        end
      end
    end
    prev_valid = kif.KEY_VALID;
  end

`ifdef KEY_RELEASE_FLAG_EN
  // Release pulses must match issued releases and coincide with KEY_DOWN falling.
  always @(negedge clk) begin
    if (kif.KEY_REL) begin
      checks++;
      if (rel_pending == 0) begin
        errors++;
        $display("FAIL unexpected_rel actual=pulse expected=none");
      end else begin
        rel_pending--;
      end
      checks++;
      if (kif.KEY_DOWN !== 1'b0) begin
        errors++;
        $display("FAIL down_with_rel actual=%b expected=0", kif.KEY_DOWN);
      end
    end
  end
`endif

  // Column trace for the clean-press scenario.
  always @(negedge clk) begin
    if (trace_en && kif.COL_OUT !== last_col) col_trace.push_back(kif.COL_OUT);
    last_col = kif.COL_OUT;
  end

  // Full press/hold/release; caller is positioned at a negedge.
  task automatic do_press(input logic [15:0] k, input int hold, input int relw,
                          input bit lat_on, input bit bouncy);
    int code;
    code = ref_code(k);
    exp_code_q.push_back(4'(code));
    exp_lat_q.push_back(lat_on ? (2 + 1 + (code % 4) * S + S + D) : -1);
    exp_cyc_q.push_back(cyc);
    if (bouncy) begin
      for (int i = 0; i < 10; i++) begin
        keys = (i % 2 == 0) ? k : 16'h0000;
        repeat (3) @(negedge clk);
      end
    end
    keys = k;
    repeat (hold) @(negedge clk);
    chk("valid_seen_pending", exp_code_q.size(), 0);
    if (exp_code_q.size() != 0) begin
      exp_code_q.delete(); exp_lat_q.delete(); exp_cyc_q.delete();
    end
    chk("down_held", kif.KEY_DOWN, 1);
    chk("code_held", kif.KEY_CODE, code);
    keys = 16'h0000;
`ifdef KEY_RELEASE_FLAG_EN
    rel_pending++;
`endif
    repeat (relw) @(negedge clk);
    chk("down_released", kif.KEY_DOWN, 0);
    chk("code_kept", kif.KEY_CODE, code);
`ifdef KEY_RELEASE_FLAG_EN
    chk("rel_pulse_seen", rel_pending, 0);
    rel_pending = 0;
`endif
  endtask

  task automatic do_glitch(input logic [15:0] k, input int dur);
    keys = k;
    repeat (dur) @(negedge clk);
    keys = 16'h0000;
    repeat (40) @(negedge clk);
    chk("glitch_col_idle", kif.COL_OUT, 4'b0000);
    chk("glitch_down", kif.KEY_DOWN, 0);
  endtask

  initial begin
    logic [15:0] k;
    int sel;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_col", kif.COL_OUT, 4'b0000);
    chk("rst_valid", kif.KEY_VALID, 0);
    chk("rst_code", kif.KEY_CODE, 4'h0);
    chk("rst_down", kif.KEY_DOWN, 0);
    nrst = 1'b1;
    repeat (5) @(negedge clk);

    // Clean press row2/col1 with column stepping trace
    trace_en = 1'b1;
    do_press(16'h0200, 60, 40, 1'b1, 1'b0);
    trace_en = 1'b0;
    chk("trace_len", col_trace.size(), 3);
    if (col_trace.size() == 3) begin
      chk("trace_c0", col_trace[0], 4'b1110);
      chk("trace_c1", col_trace[1], 4'b1101);
      chk("trace_idle", col_trace[2], 4'b0000);
    end
    repeat (8) @(negedge clk);

    // Bouncy press then stable
    do_press(16'h0200, 60, 40, 1'b0, 1'b1);
    repeat (8) @(negedge clk);

    // Glitch on row0/col0
    do_glitch(16'h0001, 8);

    // Two keys row1 and row3 on col3
    do_press(16'h8080, 60, 40, 1'b1, 1'b0);
    repeat (8) @(negedge clk);

    // Reset during press debounce (timer at 10)
    keys = 16'h0200;
    repeat (21) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("midrst_col", kif.COL_OUT, 4'b0000);
    chk("midrst_valid", kif.KEY_VALID, 0);
    chk("midrst_code", kif.KEY_CODE, 4'h0);
    chk("midrst_down", kif.KEY_DOWN, 0);
    repeat (3) @(negedge clk);
    keys = 16'h0000;
    nrst = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_rst_col", kif.COL_OUT, 4'b0000);
    chk("post_rst_down", kif.KEY_DOWN, 0);

    // Randomized presses, multi-key presses and glitches
    for (int t = 0; t < 14; t++) begin
      sel = $urandom_range(0, 3);
      k = 16'h0000;
      k[$urandom_range(0, 15)] = 1'b1;
      if (sel == 2) k[$urandom_range(0, 15)] = 1'b1;
      if (sel == 3) do_glitch(k, $urandom_range(1, 8));
      else do_press(k, $urandom_range(50, 80), $urandom_range(30, 45), 1'b1, 1'b0);
      repeat ($urandom_range(5, 10)) @(negedge clk);
    end

    chk("scoreboard_empty", exp_code_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
